ex_stage: RTL and testbench

//  Execute stage; consumes ID_EX outputs, drives EX_MEM inputs and IF redirect. Does operand forwarding, ALU ops, branch/jump resolution.

---
 rtl/ex_stage_if.sv | 43 ++++
 rtl/ex_stage.sv | 149 ++++++++++++++
 tb/tb_ex_stage.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// Port bundle for the execute stage: ID_EX operands/controls, forwarding taps
// from EX_MEM and MEM_WB, and the results going to EX_MEM and the IF redirect.
interface ex_stage_if;
    logic [31:0] pc_in;
    logic [31:0] rs1_data_in;
    logic [31:0] rs2_data_in;
    logic [31:0] imm_res_in;
    logic [4:0]  rs1_in;
    logic [4:0]  rs2_in;
    logic        alu_src_sel_A_in;
    logic [1:0]  alu_src_sel_B_in;
    logic [4:0]  alu_op_in;
    logic        jump_in;
    logic        branch_in;
    logic        pcJalSrc_in;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic [31:0] mem_fwd_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] wb_fwd_data;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [31:0] pc_target;
    logic        pc_src;
    logic        busy;

    modport master (
        output pc_in, rs1_data_in, rs2_data_in, imm_res_in, rs1_in, rs2_in,
               alu_src_sel_A_in, alu_src_sel_B_in, alu_op_in, jump_in, branch_in,
               pcJalSrc_in, mem_rd, mem_reg_write, mem_fwd_data, wb_rd,
               wb_reg_write, wb_fwd_data,
        input  alu_result, write_data, pc_target, pc_src, busy
    );

    modport slave (
        input  pc_in, rs1_data_in, rs2_data_in, imm_res_in, rs1_in, rs2_in,
               alu_src_sel_A_in, alu_src_sel_B_in, alu_op_in, jump_in, branch_in,
               pcJalSrc_in, mem_rd, mem_reg_write, mem_fwd_data, wb_rd,
               wb_reg_write, wb_fwd_data,
        output alu_result, write_data, pc_target, pc_src, busy
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU/MUL, branch/jump resolution
// and a 32-iteration restoring divider that stalls the pipe while it runs.
module ex_stage (
    input  logic     clk,
    input  logic     rst,
    ex_stage_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_e;

    div_state_e  state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] divisor_q, divisor_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        is_rem_q, is_rem_d;

    logic [31:0] fwd_rs1, fwd_rs2, op_a, op_b, alu_comb, jalr_sum;
    logic [31:0] abs_a, abs_b, quo_fix, rem_fix, div_res;
    logic [32:0] trial;
    logic        is_div, div_signed, cond, busy;

    // MEM beats WB; x0 is never forwarded so a stale write to x0 cannot leak.
    always_comb begin
        fwd_rs1 = bus.rs1_data_in;
        if (bus.mem_reg_write && bus.mem_rd != 5'd0 && bus.mem_rd == bus.rs1_in)
            fwd_rs1 = bus.mem_fwd_data;
        else if (bus.wb_reg_write && bus.wb_rd != 5'd0 && bus.wb_rd == bus.rs1_in)
            fwd_rs1 = bus.wb_fwd_data;
        fwd_rs2 = bus.rs2_data_in;
        if (bus.mem_reg_write && bus.mem_rd != 5'd0 && bus.mem_rd == bus.rs2_in)
            fwd_rs2 = bus.mem_fwd_data;
        else if (bus.wb_reg_write && bus.wb_rd != 5'd0 && bus.wb_rd == bus.rs2_in)
            fwd_rs2 = bus.wb_fwd_data;
    end

    always_comb begin
        op_a = bus.alu_src_sel_A_in ? bus.pc_in : fwd_rs1;
        case (bus.alu_src_sel_B_in)
            2'd0:    op_b = fwd_rs2;
            2'd1:    op_b = bus.imm_res_in;
            2'd2:    op_b = 32'd4;
            default: op_b = 32'd0;
        endcase
    end

    always_comb begin
        alu_comb = 32'd0;
        cond     = 1'b0;
        case (bus.alu_op_in)
            5'd0:  alu_comb = op_a + op_b;
            5'd1:  alu_comb = op_a - op_b;
            5'd2:  alu_comb = op_a & op_b;
            5'd3:  alu_comb = op_a | op_b;
            5'd4:  alu_comb = op_a ^ op_b;
            5'd5:  alu_comb = op_a << op_b[4:0];
            5'd6:  alu_comb = op_a >> op_b[4:0];
            5'd7:  alu_comb = $signed(op_a) >>> op_b[4:0];
            5'd8:  alu_comb = {31'd0, $signed(op_a) < $signed(op_b)};
            5'd9:  alu_comb = {31'd0, op_a < op_b};
            5'd10: alu_comb = op_a * op_b;
            5'd16: cond = (fwd_rs1 == fwd_rs2);
            5'd17: cond = (fwd_rs1 != fwd_rs2);
            5'd18: cond = ($signed(fwd_rs1) <  $signed(fwd_rs2));
            5'd19: cond = ($signed(fwd_rs1) >= $signed(fwd_rs2));
            5'd20: cond = (fwd_rs1 <  fwd_rs2);
            5'd21: cond = (fwd_rs1 >= fwd_rs2);
            default: ;
        endcase
    end

    // Ops 12..15 share the 0b011xx prefix; bit0=unsigned, bit1=remainder.
    assign is_div     = (bus.alu_op_in[4:2] == 3'b011);
    assign div_signed = ~bus.alu_op_in[0];
    assign abs_a      = (div_signed && op_a[31]) ? -op_a : op_a;
    assign abs_b      = (div_signed && op_b[31]) ? -op_b : op_b;
    assign trial      = {rem_q, quo_q[31]} - {1'b0, divisor_q};

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        is_rem_d  = is_rem_q;
        case (state_q)
            IDLE: if (is_div) begin
                quo_d     = abs_a;
                rem_d     = 32'd0;
                divisor_d = abs_b;
                // Divide-by-zero keeps the raw all-ones quotient unsigned.
                neg_quo_d = div_signed && (op_a[31] ^ op_b[31]) && (op_b != 32'd0);
                neg_rem_d = div_signed && op_a[31];
                is_rem_d  = bus.alu_op_in[1];
                count_d   = 5'd0;
                state_d   = RUN;
            end
            RUN: begin
                if (!trial[32]) begin
                    rem_d = trial[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = {rem_q[30:0], quo_q[31]};
                    quo_d = {quo_q[30:0], 1'b0};
                end
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= 5'd0;
            quo_q     <= 32'd0;
            rem_q     <= 32'd0;
            divisor_q <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_rem_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            is_rem_q  <= is_rem_d;
        end
    end

    assign quo_fix  = neg_quo_q ? -quo_q : quo_q;
    assign rem_fix  = neg_rem_q ? -rem_q : rem_q;
    assign div_res  = is_rem_q ? rem_fix : quo_fix;
    assign busy     = ((state_q == IDLE) && is_div) || (state_q == RUN);
    assign jalr_sum = fwd_rs1 + bus.imm_res_in;

    assign bus.busy       = busy;
    assign bus.alu_result = (state_q == DONE) ? div_res : alu_comb;
    assign bus.write_data = fwd_rs2;
    assign bus.pc_target  = bus.pcJalSrc_in ? (jalr_sum & ~32'd1) : (bus.pc_in + bus.imm_res_in);
    assign bus.pc_src     = ~busy & (bus.jump_in | (bus.branch_in & cond));
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: forwarding, ALU table, branches/jumps, divider
// latency and corner cases, and reset in the middle of a divide.
module tb_ex_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_stage_if bus();
    ex_stage dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic set_nop();
        bus.pc_in = 0; bus.rs1_data_in = 0; bus.rs2_data_in = 0; bus.imm_res_in = 0;
        bus.rs1_in = 0; bus.rs2_in = 0; bus.alu_src_sel_A_in = 0; bus.alu_src_sel_B_in = 0;
        bus.alu_op_in = 0; bus.jump_in = 0; bus.branch_in = 0; bus.pcJalSrc_in = 0;
        bus.mem_rd = 0; bus.mem_reg_write = 0; bus.mem_fwd_data = 0;
        bus.wb_rd = 0; bus.wb_reg_write = 0; bus.wb_fwd_data = 0;
    endtask

    task automatic set_rr(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        set_nop();
        bus.alu_op_in = op; bus.rs1_data_in = a; bus.rs2_data_in = b;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_nop();
        @(negedge clk); @(negedge clk); #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %h want 0", bus.busy); end
        n_checks++; if (bus.alu_result !== 32'd0) begin n_fail++; $display("FAIL reset_result got %h want 0", bus.alu_result); end
        n_checks++; if (bus.pc_src !== 1'b0) begin n_fail++; $display("FAIL reset_pc_src got %h want 0", bus.pc_src); end
        rst = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic test_forwarding();
        set_nop();
        bus.rs1_in = 5'd1; bus.rs1_data_in = 32'd9;
        bus.mem_rd = 5'd1; bus.mem_reg_write = 1'b1; bus.mem_fwd_data = 32'd5;
        bus.alu_src_sel_B_in = 2'd1; bus.imm_res_in = 32'd3;
        #1;
        n_checks++; if (bus.alu_result !== 32'd8) begin n_fail++; $display("FAIL fwd_mem got %h want 8", bus.alu_result); end
        bus.wb_rd = 5'd1; bus.wb_reg_write = 1'b1; bus.wb_fwd_data = 32'd7;
        #1;
        n_checks++; if (bus.alu_result !== 32'd8) begin n_fail++; $display("FAIL fwd_mem_wins got %h want 8", bus.alu_result); end
        bus.mem_reg_write = 1'b0;
        #1;
        n_checks++; if (bus.alu_result !== 32'd10) begin n_fail++; $display("FAIL fwd_wb got %h want a", bus.alu_result); end
        set_nop();
        bus.mem_rd = 5'd0; bus.mem_reg_write = 1'b1; bus.mem_fwd_data = 32'hDEAD;
        bus.wb_rd = 5'd0; bus.wb_reg_write = 1'b1; bus.wb_fwd_data = 32'hBEEF;
        bus.alu_src_sel_B_in = 2'd3;
        #1;
        n_checks++; if (bus.alu_result !== 32'd0) begin n_fail++; $display("FAIL fwd_x0 got %h want 0", bus.alu_result); end
        set_nop();
        bus.rs2_in = 5'd2; bus.rs2_data_in = 32'd1;
        bus.wb_rd = 5'd2; bus.wb_reg_write = 1'b1; bus.wb_fwd_data = 32'h10;
        #1;
        n_checks++; if (bus.write_data !== 32'h10) begin n_fail++; $display("FAIL fwd_store_data got %h want 10", bus.write_data); end
    endtask

    task automatic test_alu();
        logic [4:0]  ops [12] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11};
        logic [31:0] as  [12] = '{32'hFFFFFFFF, 32'd3, 32'hF0F0, 32'hF0F0, 32'hFF, 32'd1,
                                  32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'd5};
        logic [31:0] bs  [12] = '{32'd2, 32'd5, 32'hFF00, 32'h0F0F, 32'h0F, 32'd33,
                                  32'd4, 32'd4, 32'd1, 32'd1, 32'hFFFFFFFD, 32'd6};
        logic [31:0] exp [12] = '{32'd1, 32'hFFFFFFFE, 32'hF000, 32'hFFFF, 32'hF0, 32'd2,
                                  32'h08000000, 32'hF8000000, 32'd1, 32'd0, 32'hFFFFFFEB, 32'd0};
        for (int i = 0; i < 12; i++) begin
            set_rr(ops[i], as[i], bs[i]);
            #1;
            n_checks++;
            if (bus.alu_result !== exp[i] || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL alu_op%0d got %h busy %h want %h busy 0", ops[i], bus.alu_result, bus.busy, exp[i]);
            end
        end
    endtask

    task automatic test_branch();
        set_rr(5'd18, 32'hFFFFFFFF, 32'd1);
        bus.branch_in = 1'b1; bus.pc_in = 32'h100; bus.imm_res_in = 32'hFFFFFFF8;
        #1;
        n_checks++; if (bus.pc_src !== 1'b1) begin n_fail++; $display("FAIL blt_taken got %h want 1", bus.pc_src); end
        n_checks++; if (bus.pc_target !== 32'hF8) begin n_fail++; $display("FAIL blt_target got %h want f8", bus.pc_target); end
        n_checks++; if (bus.alu_result !== 32'd0) begin n_fail++; $display("FAIL blt_result got %h want 0", bus.alu_result); end
        set_rr(5'd16, 32'd1, 32'd2);
        bus.branch_in = 1'b1;
        #1;
        n_checks++; if (bus.pc_src !== 1'b0) begin n_fail++; $display("FAIL beq_not_taken got %h want 0", bus.pc_src); end
        set_rr(5'd0, 32'h203, 32'd0);
        bus.jump_in = 1'b1; bus.pcJalSrc_in = 1'b1; bus.imm_res_in = 32'd2;
        bus.alu_src_sel_A_in = 1'b1; bus.alu_src_sel_B_in = 2'd2; bus.pc_in = 32'h40;
        #1;
        n_checks++; if (bus.pc_src !== 1'b1) begin n_fail++; $display("FAIL jalr_pc_src got %h want 1", bus.pc_src); end
        n_checks++; if (bus.pc_target !== 32'h204) begin n_fail++; $display("FAIL jalr_target got %h want 204", bus.pc_target); end
        n_checks++; if (bus.alu_result !== 32'h44) begin n_fail++; $display("FAIL jalr_link got %h want 44", bus.alu_result); end
    endtask

    task automatic run_div(input string name, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        int cnt = 0;
        set_rr(op, a, b);
        bus.jump_in = 1'b1;
        #1;
        n_checks++; if (bus.pc_src !== 1'b0) begin n_fail++; $display("FAIL %s_pc_src_busy got %h want 0", name, bus.pc_src); end
        while (bus.busy === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk); #1;
        end
        n_checks++; if (cnt != 33) begin n_fail++; $display("FAIL %s_busy_cycles got %0d want 33", name, cnt); end
        n_checks++; if (bus.alu_result !== exp) begin n_fail++; $display("FAIL %s_result got %h want %h", name, bus.alu_result, exp); end
        set_nop();
        @(negedge clk); #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL %s_idle_after got %h want 0", name, bus.busy); end
    endtask

    task automatic test_divide();
        run_div("div_neg7_2",  5'd12, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
        run_div("rem_neg7_2",  5'd14, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
        run_div("divu_by0",    5'd13, 32'd100, 32'd0, 32'hFFFFFFFF);
        run_div("remu_by0",    5'd15, 32'd100, 32'd0, 32'd100);
        run_div("div_ovf",     5'd12, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run_div("rem_ovf",     5'd14, 32'h80000000, 32'hFFFFFFFF, 32'd0);
        run_div("divu_100_7",  5'd13, 32'd100, 32'd7, 32'd14);
    endtask

    task automatic test_reset_mid_div();
        set_rr(5'd12, 32'd1000, 32'd3);
        #1;
        repeat (11) @(negedge clk);
        #1;
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL middiv_running got %h want 1", bus.busy); end
        rst = 1'b1;
        set_nop();
        @(negedge clk); #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL middiv_rst_busy got %h want 0", bus.busy); end
        rst = 1'b0;
        bus.rs1_data_in = 32'd2; bus.alu_src_sel_B_in = 2'd1; bus.imm_res_in = 32'd3;
        #1;
        n_checks++; if (bus.alu_result !== 32'd5 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL middiv_add got %h busy %h want 5 busy 0", bus.alu_result, bus.busy);
        end
        @(negedge clk); #1;
        n_checks++; if (bus.alu_result !== 32'd5 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL middiv_add_next got %h busy %h want 5 busy 0", bus.alu_result, bus.busy);
        end
        set_nop();
        @(negedge clk); #1;
        run_div("div_after_rst", 5'd12, 32'd1000, 32'd3, 32'd333);
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_alu();
        test_branch();
        test_divide();
        test_reset_mid_div();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
